load_store_buffer: RTL and testbench

LOAD_STORE_BUFFER -- requirements
Module: load_store_buffer

---
 rtl/load_store_buffer.sv | 258 +++++++++++++++++++++++++
 tb/tb_load_store_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order load/store queue with one outstanding memory access.
// Entries sit in a circular FIFO; stores wait at the head until the ROB commits them.
// Optional feature macro: LSB_EMPTY_BYPASS_EN -- a load arriving at an empty, idle
// queue issues its memory request on the same edge it is enqueued.
module load_store_buffer #(
  parameter int LSB_SIZE = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ls_mission,
  input  logic [3:0]  ls_ins_rnm,
  input  logic [5:0]  ls_op_type,
  input  logic [31:0] ls_addr_offset,
  input  logic [31:0] ls_ins_rs1,
  input  logic [31:0] store_ins_rs2,
  output logic        lsb_full,
  input  logic        store_commit_flag,
  input  logic [3:0]  store_commit_rename,
  input  logic        lsb_flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_width,
  output logic [31:0] mem_wdata,
  input  logic        mem_done,
  input  logic [31:0] mem_rdata,
  output logic        lsb_cdb_flag,
  output logic [3:0]  lsb_cdb_rename,
  output logic [31:0] lsb_cdb_value,
  output logic        store_done_flag,
  output logic [3:0]  store_done_rename
);

  localparam int PTR_W = (LSB_SIZE > 1) ? $clog2(LSB_SIZE) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LSB_SIZE);
  localparam logic [CNT_W-1:0] NEAR_FULL_CNT = CNT_W'(LSB_SIZE - 1);

  localparam logic [5:0] OP_LB  = 6'd11;
  localparam logic [5:0] OP_LH  = 6'd12;
  localparam logic [5:0] OP_LBU = 6'd14;
  localparam logic [5:0] OP_LHU = 6'd15;
  localparam logic [5:0] OP_SB  = 6'd16;
  localparam logic [5:0] OP_SH  = 6'd17;
  localparam logic [5:0] OP_SW  = 6'd18;

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [5:0]  op;
    logic [3:0]  tag;
    logic        committed;
  } entry_t;

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [1:0] width_of(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 2'd0;
      OP_LH, OP_LHU, OP_SH: return 2'd1;
      default:              return 2'd2;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] rdata);
    case (op)
      OP_LB:   return {{24{rdata[7]}}, rdata[7:0]};
      OP_LBU:  return {24'd0, rdata[7:0]};
      OP_LH:   return {{16{rdata[15]}}, rdata[15:0]};
      OP_LHU:  return {16'd0, rdata[15:0]};
      default: return rdata;
    endcase
  endfunction

  entry_t ent_q [LSB_SIZE];
  entry_t ent_d [LSB_SIZE];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d, ncommit;
  state_t state_q, state_d;
  logic abandon_q, abandon_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0] mem_width_q, mem_width_d;
  logic cdb_flag_q, cdb_flag_d, sd_flag_q, sd_flag_d;
  logic [3:0] cdb_rename_q, cdb_rename_d, sd_rename_q, sd_rename_d;
  logic [31:0] cdb_value_q, cdb_value_d;

  entry_t head_e, new_entry;
  logic enq, done_act, pop, flush;

  assign head_e    = ent_q[head_q];
  assign new_entry = '{addr: ls_ins_rs1 + ls_addr_offset, data: store_ins_rs2,
                       op: ls_op_type, tag: ls_ins_rnm, committed: 1'b0};
  assign flush     = rdy && lsb_flush;
  assign enq       = rdy && ls_mission && (count_q != FULL_CNT) && !lsb_flush;
  assign done_act  = rdy && (state_q == MEM_WAIT) && mem_done;
  // An abandoned access belongs to an entry the flush already dropped, so nothing pops.
  assign pop       = done_act && !abandon_q;

  // Queue storage, commit marking, pointers and occupancy (including flush recovery).
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    ent_d   = ent_q;
    ncommit = '0;
    for (int i = 0; i < LSB_SIZE; i++) begin
      logic [PTR_W-1:0] off;
      logic             valid;
      off   = PTR_W'(i) - head_q;
      valid = {1'b0, off} < count_q;
      if (rdy && store_commit_flag && valid && is_store(ent_q[i].op) &&
          (ent_q[i].tag == store_commit_rename)) begin
        ent_d[i].committed = 1'b1;
      end
      if (valid && ent_d[i].committed) ncommit = ncommit + CNT_W'(1);
    end
    if (enq) ent_d[tail_q] = new_entry;

    head_d = head_q + PTR_W'(pop);
    if (flush) begin
      // Committed stores are always the oldest entries, so they stay contiguous at head.
      count_d = ncommit - CNT_W'(pop && head_e.committed);
      tail_d  = head_d + PTR_W'(count_d);
    end else begin
      count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
      tail_d  = tail_q + PTR_W'(enq);
    end
  end

  // Memory access FSM: issue from head in IDLE, hold the request until mem_done.
  always_comb begin
    state_d      = state_q;
    abandon_d    = abandon_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_width_d  = mem_width_q;
    mem_wdata_d  = mem_wdata_q;
    cdb_flag_d   = cdb_flag_q;
    cdb_rename_d = cdb_rename_q;
    cdb_value_d  = cdb_value_q;
    sd_flag_d    = sd_flag_q;
    sd_rename_d  = sd_rename_q;
    if (rdy) begin
      cdb_flag_d = 1'b0;
      sd_flag_d  = 1'b0;
      case (state_q)
        IDLE: begin
          abandon_d = 1'b0;
          if ((count_q != '0) &&
              (is_store(head_e.op) ? head_e.committed : !lsb_flush)) begin
            state_d     = MEM_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store(head_e.op);
            mem_addr_d  = head_e.addr;
            mem_width_d = width_of(head_e.op);
            mem_wdata_d = head_e.data;
          end
`ifdef LSB_EMPTY_BYPASS_EN
          else if ((count_q == '0) && ls_mission && !is_store(ls_op_type) && !lsb_flush) begin
            state_d     = MEM_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = new_entry.addr;
            mem_width_d = width_of(new_entry.op);
            mem_wdata_d = new_entry.data;
          end
`else
          else begin
            state_d = IDLE;
          end
`endif
        end
        MEM_WAIT: begin
          if (mem_done) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            abandon_d = 1'b0;
            if (!abandon_q) begin
              if (is_store(head_e.op)) begin
                sd_flag_d   = 1'b1;
                sd_rename_d = head_e.tag;
              end else if (!lsb_flush) begin
                cdb_flag_d   = 1'b1;
                cdb_rename_d = head_e.tag;
                cdb_value_d  = extend(head_e.op, mem_rdata);
              end
            end
          end else if (lsb_flush && !is_store(head_e.op)) begin
            abandon_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      abandon_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_width_q  <= '0;
      mem_wdata_q  <= '0;
      cdb_flag_q   <= 1'b0;
      cdb_rename_q <= '0;
      cdb_value_q  <= '0;
      sd_flag_q    <= 1'b0;
      sd_rename_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      state_q      <= state_d;
      abandon_q    <= abandon_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_width_q  <= mem_width_d;
      mem_wdata_q  <= mem_wdata_d;
      cdb_flag_q   <= cdb_flag_d;
      cdb_rename_q <= cdb_rename_d;
      cdb_value_q  <= cdb_value_d;
      sd_flag_q    <= sd_flag_d;
      sd_rename_q  <= sd_rename_d;
    end
  end

  // Entry payload storage.
  // NOTE: the entry array has no reset; an entry only matters inside the head/count window.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign lsb_full          = count_q >= NEAR_FULL_CNT;
  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_width         = mem_width_q;
  assign mem_wdata         = mem_wdata_q;
  assign lsb_cdb_flag      = cdb_flag_q;
  assign lsb_cdb_rename    = cdb_rename_q;
  assign lsb_cdb_value     = cdb_value_q;
  assign store_done_flag   = sd_flag_q;
  assign store_done_rename = sd_rename_q;

endmodule

// File: tb/tb_load_store_buffer.sv
// tb_load_store_buffer: directed stimulus with scoreboard queues; a memory responder
// and CDB/store-done monitors pop expected items and compare as the DUT presents them.
module tb_load_store_buffer;

  localparam logic [5:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14, LHU = 6'd15;
  localparam logic [5:0] SB = 6'd16, SW = 6'd18;

  logic        clk, rst, rdy;
  logic        ls_mission;
  logic [3:0]  ls_ins_rnm;
  logic [5:0]  ls_op_type;
  logic [31:0] ls_addr_offset, ls_ins_rs1, store_ins_rs2;
  logic        lsb_full;
  logic        store_commit_flag;
  logic [3:0]  store_commit_rename;
  logic        lsb_flush;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_width;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        lsb_cdb_flag;
  logic [3:0]  lsb_cdb_rename;
  logic [31:0] lsb_cdb_value;
  logic        store_done_flag;
  logic [3:0]  store_done_rename;

  load_store_buffer #(.LSB_SIZE(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ls_mission(ls_mission), .ls_ins_rnm(ls_ins_rnm), .ls_op_type(ls_op_type),
    .ls_addr_offset(ls_addr_offset), .ls_ins_rs1(ls_ins_rs1), .store_ins_rs2(store_ins_rs2),
    .lsb_full(lsb_full),
    .store_commit_flag(store_commit_flag), .store_commit_rename(store_commit_rename),
    .lsb_flush(lsb_flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_width(mem_width),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .lsb_cdb_flag(lsb_cdb_flag), .lsb_cdb_rename(lsb_cdb_rename), .lsb_cdb_value(lsb_cdb_value),
    .store_done_flag(store_done_flag), .store_done_rename(store_done_rename)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } mem_exp_t;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] value;
  } cdb_exp_t;

  mem_exp_t   exp_mem[$];
  cdb_exp_t   exp_cdb[$];
  logic [3:0] exp_sd[$];

  int n_checks = 0;
  int n_errors = 0;
  logic auto_mem;
  int   mem_lat;
  int   inject_req;
  int   inject_ack;
  logic busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory responder: checks each new request against the scoreboard, answers after mem_lat.
  initial begin
    mem_exp_t cur;
    int wait_cnt;
    mem_done   = 1'b0;
    mem_rdata  = '0;
    busy       = 1'b0;
    inject_ack = 0;
    wait_cnt   = 0;
    forever begin
      @(negedge clk);
      if (mem_done) begin
        mem_done = 1'b0;
      end else if (inject_ack != inject_req) begin
        inject_ack = inject_req;
        mem_done   = 1'b1;
        mem_rdata  = 32'h5555_5555;
      end else if (busy) begin
        if (wait_cnt == 0) begin
          mem_done  = 1'b1;
          mem_rdata = cur.rdata;
          busy      = 1'b0;
        end else begin
          wait_cnt--;
        end
      end else if (auto_mem && mem_req) begin
        if (exp_mem.size() == 0) begin
          check("mem_req_unexpected", {31'd0, mem_req}, 32'd0);
        end else begin
          cur = exp_mem.pop_front();
          check("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
          check("mem_addr", mem_addr, cur.addr);
          check("mem_width", {30'd0, mem_width}, {30'd0, cur.width});
          if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
          busy     = 1'b1;
          wait_cnt = mem_lat;
        end
      end
    end
  end

  // CDB monitor.
  initial forever begin
    cdb_exp_t e;
    @(negedge clk);
    if (lsb_cdb_flag) begin
      if (exp_cdb.size() == 0) begin
        check("cdb_unexpected", {28'd0, lsb_cdb_rename}, 32'hFFFF_FFFF);
      end else begin
        e = exp_cdb.pop_front();
        check("cdb_tag", {28'd0, lsb_cdb_rename}, {28'd0, e.tag});
        check("cdb_value", lsb_cdb_value, e.value);
      end
    end
  end

  // Store-done monitor.
  initial forever begin
    logic [3:0] t;
    @(negedge clk);
    if (store_done_flag) begin
      if (exp_sd.size() == 0) begin
        check("store_done_unexpected", {28'd0, store_done_rename}, 32'hFFFF_FFFF);
      end else begin
        t = exp_sd.pop_front();
        check("store_done_tag", {28'd0, store_done_rename}, {28'd0, t});
        check("store_done_no_cdb", {31'd0, lsb_cdb_flag}, 32'd0);
      end
    end
  end

  task automatic exp_load(input logic [31:0] addr, input logic [1:0] w, input logic [31:0] rdata,
                          input logic [3:0] tag, input logic [31:0] value);
    exp_mem.push_back('{we: 1'b0, addr: addr, width: w, wdata: 32'd0, rdata: rdata});
    exp_cdb.push_back('{tag: tag, value: value});
  endtask

  task automatic exp_store(input logic [31:0] addr, input logic [1:0] w, input logic [31:0] wdata,
                           input logic [3:0] tag);
    exp_mem.push_back('{we: 1'b1, addr: addr, width: w, wdata: wdata, rdata: 32'd0});
    exp_sd.push_back(tag);
  endtask

  task automatic enq(input logic [5:0] op, input logic [3:0] tag, input logic [31:0] rs1,
                     input logic [31:0] off, input logic [31:0] data);
    ls_mission     = 1'b1;
    ls_op_type     = op;
    ls_ins_rnm     = tag;
    ls_ins_rs1     = rs1;
    ls_addr_offset = off;
    store_ins_rs2  = data;
    @(negedge clk);
    ls_mission = 1'b0;
  endtask

  task automatic commit(input logic [3:0] tag);
    store_commit_flag   = 1'b1;
    store_commit_rename = tag;
    @(negedge clk);
    store_commit_flag = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    logic drained;
    drained = 1'b0;
    for (int c = 0; c < budget && !drained; c++) begin
      if (exp_mem.size() == 0 && exp_cdb.size() == 0 && exp_sd.size() == 0 &&
          !busy && !mem_req && !mem_done) drained = 1'b1;
      else @(negedge clk);
    end
    check(name, {31'd0, drained}, 32'd1);
  endtask

  task automatic wait_mem_req(input string name, input int budget);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      if (mem_req) seen = 1'b1;
      else @(negedge clk);
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_sd_left(input string name, input int left, input int budget);
    logic ok;
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      if (exp_sd.size() == left && !mem_done) ok = 1'b1;
      else @(negedge clk);
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; rdy = 1'b1;
    ls_mission = 1'b0; ls_ins_rnm = '0; ls_op_type = '0;
    ls_addr_offset = '0; ls_ins_rs1 = '0; store_ins_rs2 = '0;
    store_commit_flag = 1'b0; store_commit_rename = '0; lsb_flush = 1'b0;
    auto_mem = 1'b1; mem_lat = 1; inject_req = 0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_lsb_full", {31'd0, lsb_full}, 32'd0);
    check("rst_cdb_flag", {31'd0, lsb_cdb_flag}, 32'd0);
    check("rst_store_done", {31'd0, store_done_flag}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_cdb_value", lsb_cdb_value, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // LW base+offset.
    exp_load(32'h104, 2'd2, 32'h89AB_CDEF, 4'd1, 32'h89AB_CDEF);
    enq(LW, 4'd1, 32'h100, 32'd4, 32'd0);
    wait_drain("drain_lw", 50);

    // Byte/half extension and 32-bit address wrap, issued back to back.
    exp_load(32'h203, 2'd0, 32'h0000_0080, 4'd2, 32'hFFFF_FF80);
    exp_load(32'h204, 2'd0, 32'h0000_0080, 4'd5, 32'h0000_0080);
    exp_load(32'h206, 2'd1, 32'h0000_8001, 4'd6, 32'hFFFF_8001);
    exp_load(32'h206, 2'd1, 32'h0000_8001, 4'd7, 32'h0000_8001);
    exp_load(32'h4,   2'd2, 32'hCAFE_F00D, 4'd8, 32'hCAFE_F00D);
    enq(LB,  4'd2, 32'h200, 32'd3, 32'd0);
    enq(LBU, 4'd5, 32'h200, 32'd4, 32'd0);
    enq(LH,  4'd6, 32'h200, 32'd6, 32'd0);
    enq(LHU, 4'd7, 32'h200, 32'd6, 32'd0);
    enq(LW,  4'd8, 32'hFFFF_FFFC, 32'd8, 32'd0);
    wait_drain("drain_ext", 100);

    // Store blocks a younger load until committed; store goes first.
    exp_store(32'h300, 2'd2, 32'hDEAD_BEEF, 4'd3);
    exp_load(32'h300, 2'd2, 32'hDEAD_BEEF, 4'd4, 32'hDEAD_BEEF);
    enq(SW, 4'd3, 32'h300, 32'd0, 32'hDEAD_BEEF);
    enq(LW, 4'd4, 32'h300, 32'd0, 32'd0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("sw_blocks_%0d", c), {31'd0, mem_req}, 32'd0);
      @(negedge clk);
    end
    commit(4'd3);
    wait_drain("drain_sw_lw", 50);

    // Fill/full boundary over three wrap rounds; round 1 also tries a 9th entry.
    for (int r = 0; r < 3; r++) begin
      int n;
      n = (r == 1) ? 8 : 7;
      for (int i = 0; i < n; i++) begin
        logic [31:0] a, d;
        a = 32'h1000 + 32'(r) * 32'h100 + 32'(i) * 32'd4;
        d = 32'hA000_0000 | (32'(r) << 8) | 32'(i);
        exp_store(a, 2'd2, d, 4'(i));
        enq(SW, 4'(i), a, 32'd0, d);
        check($sformatf("full_r%0d_e%0d", r, i), {31'd0, lsb_full}, {31'd0, (i + 1 >= 7)});
      end
      if (r == 1) begin
        enq(SW, 4'd15, 32'h9999_0000, 32'd0, 32'h9999_9999);
        check("full_at_capacity", {31'd0, lsb_full}, 32'd1);
      end
      commit(4'd0);
      wait_sd_left($sformatf("pop_one_r%0d", r), n - 1, 50);
      check($sformatf("full_after_pop_r%0d", r), {31'd0, lsb_full}, {31'd0, (n - 1 >= 7)});
      for (int i = 1; i < n; i++) commit(4'(i));
      if (r == 1) commit(4'd15);
      wait_drain($sformatf("drain_fill_r%0d", r), 200);
      check($sformatf("empty_after_r%0d", r), {31'd0, lsb_full}, 32'd0);
    end

    // Flush: committed SW in flight completes, uncommitted SB and LW are dropped.
    mem_lat = 4;
    exp_store(32'h500, 2'd2, 32'h1111_2222, 4'd7);
    enq(SW, 4'd7, 32'h500, 32'd0, 32'h1111_2222);
    enq(SB, 4'd8, 32'h504, 32'd0, 32'h0000_0033);
    enq(LW, 4'd9, 32'h508, 32'd0, 32'd0);
    commit(4'd7);
    wait_mem_req("flush_sw_issue", 20);
    lsb_flush = 1'b1;
    @(negedge clk);
    lsb_flush = 1'b0;
    wait_drain("drain_flush_sw", 50);
    exp_load(32'h600, 2'd2, 32'h1234_5678, 4'd10, 32'h1234_5678);
    enq(LW, 4'd10, 32'h600, 32'd0, 32'd0);
    wait_drain("after_flush_empty", 50);

    // Flush with a load in flight: access completes, CDB pulse suppressed.
    exp_mem.push_back('{we: 1'b0, addr: 32'h700, width: 2'd2, wdata: 32'd0, rdata: 32'h7777_7777});
    enq(LW, 4'd11, 32'h700, 32'd0, 32'd0);
    wait_mem_req("flush_lw_issue", 20);
    lsb_flush = 1'b1;
    @(negedge clk);
    lsb_flush = 1'b0;
    wait_drain("drain_flush_lw", 50);
    mem_lat = 1;
    exp_load(32'h704, 2'd2, 32'h0BAD_F00D, 4'd12, 32'h0BAD_F00D);
    enq(LW, 4'd12, 32'h704, 32'd0, 32'd0);
    wait_drain("after_flush_lw", 50);

    // Reset in MEM_WAIT abandons the access; a late mem_done is ignored.
    auto_mem = 1'b0;
    enq(LW, 4'd13, 32'h800, 32'd0, 32'd0);
    wait_mem_req("rst_lw_issue", 20);
    check("rst_lw_addr", mem_addr, 32'h800);
    rst = 1'b0;
    #1;
    check("rst_async_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_async_mem_addr", mem_addr, 32'd0);
    check("rst_async_full", {31'd0, lsb_full}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    inject_req++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("late_done_no_cdb_%0d", c), {31'd0, lsb_cdb_flag}, 32'd0);
      check($sformatf("late_done_no_req_%0d", c), {31'd0, mem_req}, 32'd0);
    end
    auto_mem = 1'b1;
    exp_load(32'h900, 2'd2, 32'h0000_2468, 4'd14, 32'h0000_2468);
    enq(LW, 4'd14, 32'h900, 32'd0, 32'd0);
    wait_drain("after_reset", 50);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
